fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv_pkg.sv | 6 +
 rtl/fetch_skid.sv | 29 ++
 rtl/fetch_unit.sv | 86 ++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared constants and state type for the fetch stage.
package rv_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} fetch_state_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer holding a fetched word while decode is stalled.
// Ports: clk/rst; clear_i drops the entry; load_i captures instr_i/pc_i;
// instr_o/pc_o/valid_o present the held entry.
module fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);
    logic [31:0] instr_q, pc_q;
    logic        valid_q;
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with one outstanding imem request and IF/ID register.
// Ports: clk/rst; stall/flush/PCTargetE from hazard unit; imem_req/imem_addr/
// imem_gnt/imem_rvalid/imem_rdata memory handshake; InstrD/PCD/PCPlus4D/ValidD IF/ID.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    fetch_state_t state_q;
    logic [31:0]  pcf_q, instr_q, pcd_q, pcp4_q;
    logic         valid_q;
    logic [31:0]  skid_instr, skid_pc;
    logic         skid_valid;
    logic         skid_load_d, skid_clear_d, deliver_d;
    logic [31:0]  deliver_instr_d, deliver_pc_d;
    // A response arriving under stall parks in the skid buffer; HOLD drains it.
    assign skid_load_d     = !flush && stall && state_q == S_WAIT && imem_rvalid;
    assign skid_clear_d    = flush || (state_q == S_HOLD && !stall);
    assign deliver_d       = (state_q == S_WAIT && imem_rvalid) || (state_q == S_HOLD && skid_valid);
    assign deliver_instr_d = state_q == S_HOLD ? skid_instr : imem_rdata;
    assign deliver_pc_d    = state_q == S_HOLD ? skid_pc : pcf_q;
    fetch_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (skid_clear_d),
        .load_i  (skid_load_d),
        .instr_i (imem_rdata),
        .pc_i    (pcf_q),
        .instr_o (skid_instr),
        .pc_o    (skid_pc),
        .valid_o (skid_valid)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pcf_q   <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pcp4_q  <= '0;
        end else if (flush) begin
            // A granted-but-unanswered request must have its response discarded.
            state_q <= ((state_q == S_WAIT && !imem_rvalid) || (state_q == S_REQ && imem_gnt)) ? S_DROP : S_REQ;
            pcf_q   <= PCTargetE;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else begin
            case (state_q)
                S_REQ:   if (imem_gnt) state_q <= S_WAIT;
                S_WAIT:  if (imem_rvalid) state_q <= stall ? S_HOLD : S_REQ;
                S_HOLD:  if (!stall) state_q <= S_REQ;
                default: if (imem_rvalid) state_q <= S_REQ;
            endcase
            if (!stall) begin
                valid_q <= deliver_d;
                instr_q <= deliver_d ? deliver_instr_d : NOP_INSTR;
                if (deliver_d) begin
                    pcf_q  <= pcf_q + 32'd4;
                    pcd_q  <= deliver_pc_d;
                    pcp4_q <= deliver_pc_d + 32'd4;
                end
            end
        end
    end
    assign imem_req  = state_q == S_REQ;
    assign imem_addr = pcf_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcp4_q;
    assign ValidD    = valid_q;
endmodule
